// File: rtl/wb_stage_if.sv
// MEM->WB bundle: pipeline control, MEM-stage fields, data-memory read word,
// and the register-file write port / retire outputs driven back by wb_stage.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FUNCTION_3
`define FUNCTION_3 3
`endif

interface wb_stage_if;
  logic                     stall;
  logic                     flush;
  logic                     mem_valid;
  logic                     mem_reg_write;
  logic [4:0]               mem_rd_addr;
  logic [`FUNCTION_3-1:0]   mem_funct3;
  logic [1:0]               mem_wb_data_sel;
  logic [`DATA_WIDTH-1:0]   mem_alu_result;
  logic [`DATA_WIDTH-1:0]   mem_pc4;
  logic [`DATA_WIDTH-1:0]   mem_imm;
  logic [`DATA_WIDTH-1:0]   dm_rdata;
  logic                     reg_write;
  logic [4:0]               reg_rd_addr;
  logic [`DATA_WIDTH-1:0]   reg_rd_data;
  logic                     wb_valid;
  logic [63:0]              instret;

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_funct3,
           mem_wb_data_sel, mem_alu_result, mem_pc4, mem_imm, dm_rdata,
    input  reg_write, reg_rd_addr, reg_rd_data, wb_valid, instret
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_rd_addr, mem_funct3,
           mem_wb_data_sel, mem_alu_result, mem_pc4, mem_imm, dm_rdata,
    output reg_write, reg_rd_addr, reg_rd_data, wb_valid, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register with stall/flush, load alignment and
// extension, write-back source select, and a 64-bit retired-instruction counter.
module wb_stage (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_IMM  = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic                   valid;
    logic                   reg_write;
    logic [4:0]             rd;
    logic [`FUNCTION_3-1:0] funct3;
    wb_sel_e                sel;
    logic [`DATA_WIDTH-1:0] alu;
    logic [`DATA_WIDTH-1:0] pc4;
    logic [`DATA_WIDTH-1:0] imm;
  } mem_wb_t;

  mem_wb_t     mem_wb_d, mem_wb_q;
  logic [63:0] instret_d, instret_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_wb_d  = mem_wb_q;
    instret_d = instret_q;
    if (bus.flush) begin
      mem_wb_d.valid     = 1'b0;
      mem_wb_d.reg_write = 1'b0;
    end else if (!bus.stall) begin
      mem_wb_d.valid     = bus.mem_valid;
      mem_wb_d.reg_write = bus.mem_reg_write;
      mem_wb_d.rd        = bus.mem_rd_addr;
      mem_wb_d.funct3    = bus.mem_funct3;
      mem_wb_d.sel       = wb_sel_e'(bus.mem_wb_data_sel);
      mem_wb_d.alu       = bus.mem_alu_result;
      mem_wb_d.pc4       = bus.mem_pc4;
      mem_wb_d.imm       = bus.mem_imm;
    end
    // An instruction retires on the edge it leaves WB, which a stall prevents.
    if (mem_wb_q.valid && !bus.stall) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wb_q  <= '0;
      instret_q <= '0;
    end else begin
      mem_wb_q  <= mem_wb_d;
      instret_q <= instret_d;
    end
  end

  logic [1:0]             off;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [`DATA_WIDTH-1:0] load_data;
  logic [`DATA_WIDTH-1:0] wb_data;

  always_comb begin
    off     = mem_wb_q.alu[1:0];
    ld_byte = bus.dm_rdata[{off, 3'b000} +: 8];
    ld_half = off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    unique case (mem_wb_q.funct3)
      3'b000:  load_data = {{(`DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(`DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(`DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(`DATA_WIDTH-16){1'b0}}, ld_half};
      default: load_data = bus.dm_rdata;
    endcase
  end

  always_comb begin
    unique case (mem_wb_q.sel)
      SEL_LOAD: wb_data = load_data;
      SEL_PC4:  wb_data = mem_wb_q.pc4;
      SEL_IMM:  wb_data = mem_wb_q.imm;
      default:  wb_data = mem_wb_q.alu;
    endcase
  end

  // Writes to x0 are suppressed here so the register file never sees them.
  assign bus.reg_write   = mem_wb_q.valid && mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0);
  assign bus.reg_rd_addr = mem_wb_q.rd;
  assign bus.reg_rd_data = wb_data;
  assign bus.wb_valid    = mem_wb_q.valid;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus stall/flush/reset
// sequences, with expectations queued at drive time and popped after the edge.
`timescale 1ns/1ps
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if bus ();
  wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic        stall, flush, valid, rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic [31:0] alu, pc4, imm, dm;
    logic        exp_rw;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        valid;
    logic [63:0] instret;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [63:0] exp_instret = 64'd0;
  logic        model_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic stall, input logic flush,
                              input logic valid, input logic rw, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [1:0] sel,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] imm, input logic [31:0] dm,
                              input logic exp_rw, input logic [4:0] exp_addr,
                              input logic [31:0] exp_data, input logic exp_valid);
    vec_t v;
    v.name = name; v.stall = stall; v.flush = flush; v.valid = valid; v.rw = rw;
    v.rd = rd; v.f3 = f3; v.sel = sel; v.alu = alu; v.pc4 = pc4; v.imm = imm; v.dm = dm;
    v.exp_rw = exp_rw; v.exp_addr = exp_addr; v.exp_data = exp_data; v.exp_valid = exp_valid;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.stall           = v.stall;
    bus.flush           = v.flush;
    bus.mem_valid       = v.valid;
    bus.mem_reg_write   = v.rw;
    bus.mem_rd_addr     = v.rd;
    bus.mem_funct3      = v.f3;
    bus.mem_wb_data_sel = v.sel;
    bus.mem_alu_result  = v.alu;
    bus.mem_pc4         = v.pc4;
    bus.mem_imm         = v.imm;
  endtask

  task automatic compare_outputs(input exp_t e);
    check({e.name, ".reg_write"},   {63'd0, bus.reg_write},   {63'd0, e.rw});
    check({e.name, ".reg_rd_addr"}, {59'd0, bus.reg_rd_addr}, {59'd0, e.addr});
    check({e.name, ".reg_rd_data"}, {32'd0, bus.reg_rd_data}, {32'd0, e.data});
    check({e.name, ".wb_valid"},    {63'd0, bus.wb_valid},    {63'd0, e.valid});
    check({e.name, ".instret"},     bus.instret,              e.instret);
  endtask

  // One cycle: drive at negedge, queue expectation, supply dm_rdata in WB, compare.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    if (model_valid && !v.stall) exp_instret = exp_instret + 64'd1;
    model_valid = v.flush ? 1'b0 : (v.stall ? model_valid : v.valid);
    e.name = v.name; e.rw = v.exp_rw; e.addr = v.exp_addr;
    e.data = v.exp_data; e.valid = v.exp_valid; e.instret = exp_instret;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.dm_rdata = v.dm;
    #1;
    if (sb.size() == 0) begin
      check({v.name, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      compare_outputs(sb.pop_front());
    end
  endtask

  // Reset with live inputs and stall asserted; everything must clear on that edge.
  task automatic reset_cycle(input string name);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    drive(mk(name, 1'b1, 1'b0, 1'b1, 1'b1, 5'd21, 3'd0, 2'd2, 32'h1, 32'h2, 32'h3, 32'h0,
             1'b0, 5'd0, 32'd0, 1'b0));
    exp_instret = 64'd0;
    model_valid = 1'b0;
    e.name = name; e.rw = 1'b0; e.addr = 5'd0; e.data = 32'd0; e.valid = 1'b0; e.instret = 64'd0;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.dm_rdata = 32'hFFFF_FFFF;
    #1 compare_outputs(sb.pop_front());
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [31:0] DM  = 32'h80FF_7F01;
  localparam logic [31:0] JNK = 32'hA5A5_5A5A;

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk("alu_wb",  0,0,1,1,5'd5, 3'd0,2'd0,32'h1234_5678,32'h1000,32'h5000,JNK, 1,5'd5, 32'h1234_5678,1));
    vecs.push_back(mk("x0_supp", 0,0,1,1,5'd0, 3'd0,2'd0,32'h0000_DEAD,32'h1000,32'h5000,JNK, 0,5'd0, 32'h0000_DEAD,1));
    vecs.push_back(mk("lb_off3", 0,0,1,1,5'd10,3'd0,2'd1,32'h0000_0103,32'h0,    32'h0,   DM,  1,5'd10,32'hFFFF_FF80,1));
    vecs.push_back(mk("lbu_off3",0,0,1,1,5'd11,3'd4,2'd1,32'h0000_0003,32'h0,    32'h0,   DM,  1,5'd11,32'h0000_0080,1));
    vecs.push_back(mk("lh_off2", 0,0,1,1,5'd12,3'd1,2'd1,32'h0000_0002,32'h0,    32'h0,   DM,  1,5'd12,32'hFFFF_80FF,1));
    vecs.push_back(mk("lhu_off0",0,0,1,1,5'd13,3'd5,2'd1,32'h0000_0100,32'h0,    32'h0,   DM,  1,5'd13,32'h0000_7F01,1));
    vecs.push_back(mk("lw_off2", 0,0,1,1,5'd14,3'd2,2'd1,32'h0000_0202,32'h0,    32'h0,   DM,  1,5'd14,32'h80FF_7F01,1));
    vecs.push_back(mk("lb_off1", 0,0,1,1,5'd15,3'd0,2'd1,32'h0000_0001,32'h0,    32'h0,   DM,  1,5'd15,32'h0000_007F,1));
    vecs.push_back(mk("lb_off0", 0,0,1,1,5'd18,3'd0,2'd1,32'h0000_0000,32'h0,    32'h0,   DM,  1,5'd18,32'h0000_0001,1));
    vecs.push_back(mk("lbu_off2",0,0,1,1,5'd19,3'd4,2'd1,32'h0000_0002,32'h0,    32'h0,   DM,  1,5'd19,32'h0000_00FF,1));
    vecs.push_back(mk("lh_off3", 0,0,1,1,5'd16,3'd1,2'd1,32'h0000_0003,32'h0,    32'h0,   DM,  1,5'd16,32'hFFFF_80FF,1));
    vecs.push_back(mk("lhu_off2",0,0,1,1,5'd20,3'd5,2'd1,32'h0000_0002,32'h0,    32'h0,   DM,  1,5'd20,32'h0000_80FF,1));
    vecs.push_back(mk("ld_f3_7", 0,0,1,1,5'd17,3'd7,2'd1,32'h0000_0001,32'h0,    32'h0,   DM,  1,5'd17,32'h80FF_7F01,1));
    vecs.push_back(mk("pc4_sel", 0,0,1,1,5'd1, 3'd0,2'd2,32'h0000_0055,32'h104,  32'h5000,JNK, 1,5'd1, 32'h0000_0104,1));
    vecs.push_back(mk("imm_sel", 0,0,1,1,5'd31,3'd0,2'd3,32'h0000_0055,32'h104,  32'hABCD_E000,JNK,1,5'd31,32'hABCD_E000,1));
    vecs.push_back(mk("bubble",  0,0,0,1,5'd3, 3'd0,2'd0,32'h0000_0033,32'h0,    32'h0,   JNK, 0,5'd3, 32'h0000_0033,0));
    vecs.push_back(mk("store",   0,0,1,0,5'd4, 3'd0,2'd0,32'h0000_0044,32'h0,    32'h0,   JNK, 0,5'd4, 32'h0000_0044,1));

    rst = 1'b0;
    drive(mk("init", 0,1,1,1,5'd9,3'd0,2'd3,32'h9,32'h9,32'h9,JNK, 0,5'd0,32'd0,0));
    bus.dm_rdata = JNK;
    repeat (3) @(posedge clk);
    #1;
    check("reset.reg_write",   {63'd0, bus.reg_write},   64'd0);
    check("reset.reg_rd_addr", {59'd0, bus.reg_rd_addr}, 64'd0);
    check("reset.reg_rd_data", {32'd0, bus.reg_rd_data}, 64'd0);
    check("reset.wb_valid",    {63'd0, bus.wb_valid},    64'd0);
    check("reset.instret",     bus.instret,              64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Stall three cycles with rd=7 in WB, then release into a bubble.
    step(mk("stall_load", 0,0,1,1,5'd7,3'd0,2'd0,32'h77,32'h0,32'h0,JNK, 1,5'd7,32'h77,1));
    for (int i = 0; i < 3; i++)
      step(mk("stall_hold", 1,0,1,1,5'd9,3'd4,2'd2,32'h99,32'h999,32'h0,JNK, 1,5'd7,32'h77,1));
    step(mk("stall_rel", 0,0,0,0,5'd0,3'd0,2'd0,32'h0,32'h0,32'h0,JNK, 0,5'd0,32'h0,0));

    // Flush together with stall: bubble loaded, departing instruction not counted.
    step(mk("fs_load", 0,0,1,1,5'd7,3'd0,2'd0,32'h77,32'h0,32'h0,JNK, 1,5'd7,32'h77,1));
    step(mk("fs_flush",1,1,1,1,5'd9,3'd0,2'd2,32'h99,32'h999,32'h0,JNK, 0,5'd7,32'h77,0));
    step(mk("fs_after",0,0,1,1,5'd2,3'd0,2'd0,32'h22,32'h0,32'h0,JNK, 1,5'd2,32'h22,1));

    // Flush alone: bubble loaded, departing instruction counted.
    step(mk("f_load",  0,0,1,1,5'd8,3'd0,2'd0,32'h88,32'h0,32'h0,JNK, 1,5'd8,32'h88,1));
    step(mk("f_flush", 0,1,1,1,5'd9,3'd0,2'd2,32'h99,32'h999,32'h0,JNK, 0,5'd8,32'h88,0));
    step(mk("f_after", 0,0,1,1,5'd6,3'd0,2'd0,32'h66,32'h0,32'h0,JNK, 1,5'd6,32'h66,1));

    // Reset mid-stream, then resume counting from zero.
    step(mk("rm_load", 0,0,1,1,5'd5,3'd0,2'd3,32'h55,32'h0,32'h5555,JNK, 1,5'd5,32'h5555,1));
    reset_cycle("reset_mid");
    step(mk("rm_after1",0,0,1,1,5'd12,3'd0,2'd0,32'hC0DE,32'h0,32'h0,JNK, 1,5'd12,32'hC0DE,1));
    step(mk("rm_after2",0,0,0,0,5'd0,3'd0,2'd0,32'h0,32'h0,32'h0,JNK, 0,5'd0,32'h0,0));

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
